// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and defaults for the data-memory arbiter.
//   arb_state_e        - arbiter FSM state (IDLE=0, CPU_ACC=1, HOST_ACC=2)
//   MEM_LAT_DEFAULT    - default memory access latency in cycles
//   STARVE_MAX_DEFAULT - default host denials before a forced host grant
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_ACC  = 2'd1,
    HOST_ACC = 2'd2
  } arb_state_e;

  localparam int unsigned MEM_LAT_DEFAULT    = 2;
  localparam int unsigned STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: 16-bit saturating event counter.
//   clock   - system clock, posedge
//   clear_i - synchronous clear (wins over enable)
//   en_i    - count enable, one increment per cycle
//   count_o - current count, sticks at 16'hFFFF
module sat_counter (
  input  logic        clock,
  input  logic        clear_i,
  input  logic        en_i,
  output logic [15:0] count_o
);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != '1)) count_d = count_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (clear_i) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the MEM-stage CPU port and a
// host/loader port. Each access takes MEM_LAT strobe cycles, preceded by one
// IDLE arbitration cycle. CPU has fixed priority; after STARVE_MAX CPU grants
// that denied a waiting host, the host is forced to win the next arbitration.
//
// Ports:
//   clock, reset                         - posedge clock, sync active-high reset
//   cpu_read/cpu_write/cpu_addr/cpu_wdata - MEM-stage request (level)
//   cpu_rdata                            - load data (pass-through in last cycle)
//   cpu_stall                            - freezes the pipeline while pending
//   host_req/host_we/host_addr/host_wdata - host request (level until host_done)
//   host_rdata                           - registered host read data
//   host_done                            - one-cycle completion pulse
//   mem_addr/mem_wdata/mem_we/mem_re     - memory side, stable over an access
//   mem_rdata                            - memory data, valid in last strobe cycle
//
// Build option DMEM_ARB_PERF_EN adds cpu_stall_cycles / host_wait_cycles
// saturating 16-bit performance counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT    = MEM_LAT_DEFAULT,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT,
  parameter int unsigned AW         = 16,
  parameter int unsigned DW         = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_read,
  input  logic          cpu_write,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic [DW-1:0] host_rdata,
  output logic          host_done,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [15:0]   cpu_stall_cycles,
  output logic [15:0]   host_wait_cycles
`endif
);

  localparam int unsigned LW = $clog2(MEM_LAT + 1);
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  arb_state_e    state_q, state_d;
  logic [LW-1:0] lat_cnt_q, lat_cnt_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] host_rdata_q, host_rdata_d;

  logic cpu_req, host_force, cpu_grant, host_grant;
  logic cpu_last, host_last, busy;

  assign cpu_req    = cpu_read | cpu_write;
  assign host_force = host_req & (starve_cnt_q == SW'(STARVE_MAX));
  assign cpu_grant  = (state_q == IDLE) & cpu_req & ~host_force;
  assign host_grant = (state_q == IDLE) & host_req & ~cpu_grant;
  assign cpu_last   = (state_q == CPU_ACC)  & (lat_cnt_q == '0);
  assign host_last  = (state_q == HOST_ACC) & (lat_cnt_q == '0);
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (cpu_grant) begin
          state_d   = CPU_ACC;
          lat_cnt_d = LW'(MEM_LAT - 1);
          addr_d    = cpu_addr;
          wdata_d   = cpu_wdata;
          // A simultaneous read is dropped: the store is what gets performed.
          we_d      = cpu_write;
          if (host_req && (starve_cnt_q != SW'(STARVE_MAX)))
            starve_cnt_d = starve_cnt_q + SW'(1);
        end else if (host_grant) begin
          state_d      = HOST_ACC;
          lat_cnt_d    = LW'(MEM_LAT - 1);
          addr_d       = host_addr;
          wdata_d      = host_wdata;
          we_d         = host_we;
          starve_cnt_d = '0;
        end
      end
      CPU_ACC, HOST_ACC: begin
        if (lat_cnt_q == '0) state_d = IDLE;
        else                 lat_cnt_d = lat_cnt_q - LW'(1);
      end
      default: state_d = IDLE;
    endcase

    if (cpu_last)              cpu_rdata_d  = mem_rdata;
    if (host_last && !we_q)    host_rdata_d = mem_rdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  assign mem_re     = busy & ~we_q;
  assign mem_we     = busy & we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  // Last CPU cycle forwards memory data so the pipeline can advance at once.
  assign cpu_rdata  = cpu_last ? mem_rdata : cpu_rdata_q;
  assign cpu_stall  = cpu_req & ~cpu_last;
  assign host_done  = host_last;
  assign host_rdata = host_rdata_q;

`ifdef DMEM_ARB_PERF_EN
  sat_counter u_stall_cnt (
    .clock   (clock),
    .clear_i (reset),
    .en_i    (cpu_stall),
    .count_o (cpu_stall_cycles)
  );

  sat_counter u_host_wait_cnt (
    .clock   (clock),
    .clear_i (reset),
    .en_i    ((state_q == IDLE) & host_req & ~host_grant),
    .count_o (host_wait_cycles)
  );
`endif

endmodule
